// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared widths, fetch-step numbering and FSM encoding for the
//           micro_sequencer block.
// Revision: 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int SEQ_STEP_BITS   = 3;
    localparam int SEQ_OPCODE_BITS = 8;
    localparam int FETCH_STEPS     = 2;
    localparam int FETCH_STEP_PC   = 0;
    localparam int FETCH_STEP_IR   = 1;

    typedef enum logic [0:0] {
        SEQ_RUN  = 1'b0,
        SEQ_PARK = 1'b1
    } seq_state_e;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_step_counter.sv
`default_nettype none
// ============================================================================
// Module  : seq_step_counter
// Brief   : Modulo-2**W step counter with async clear, hold, sync clear and
//           increment (priority in that order).
// Revision: 1.0 - initial release
// ============================================================================
module seq_step_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (hold_i) begin
            count_d = count_q;
        end else if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : seq_step_counter
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : micro_sequencer
// Brief   : Microcode step sequencer: hardwired 2-step fetch, then execute
//           steps addressed by {opcode, step}. Optional single-step parking
//           is enabled by defining SEQ_SINGLE_STEP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int STEP_BITS   = SEQ_STEP_BITS,
    parameter int OPCODE_BITS = SEQ_OPCODE_BITS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [15:0]                    ir_value,
    input  logic                           urst,
    input  logic                           halt,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                           ss_mode,
    input  logic                           ss_go,
    output logic                           ss_waiting,
`endif
    output logic [STEP_BITS-1:0]           step,
    output logic [OPCODE_BITS+STEP_BITS-1:0] uaddr,
    output logic                           fetch,
    output logic                           f_pc_en,
    output logic                           f_ar_load,
    output logic                           f_mem_en,
    output logic                           f_ir_load,
    output logic                           f_pc_inc
);

    localparam logic [STEP_BITS-1:0] c_fetch_steps = STEP_BITS'(FETCH_STEPS);
    localparam logic [STEP_BITS-1:0] c_step_pc     = STEP_BITS'(FETCH_STEP_PC);
    localparam logic [STEP_BITS-1:0] c_step_ir     = STEP_BITS'(FETCH_STEP_IR);
    localparam logic [STEP_BITS-1:0] c_step_last   = '1;

    logic                 w_in_fetch;
    logic                 w_end_instr;
    logic                 w_parked;
    logic                 w_park_now;
    logic                 w_frozen;
    logic                 w_cnt_hold;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;
    logic [STEP_BITS-1:0] w_step;

    assign w_in_fetch  = (w_step < c_fetch_steps);
    // urst is only honoured once the fetch steps are complete
    assign w_end_instr = !w_in_fetch && (urst || (w_step == c_step_last));

`ifdef SEQ_SINGLE_STEP_EN
    seq_state_e state_q;
    seq_state_e state_d;
    logic       start_q;
    logic       start_d;

    // start_q marks the first live edge after reset, which counts as a step-0 entry
    assign start_d    = start_q && halt;
    assign w_parked   = (state_q == SEQ_PARK);
    assign w_park_now = start_q && ss_mode;
    assign ss_waiting = w_parked;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_RUN: begin
                if (!halt && ss_mode && (w_end_instr || start_q)) begin
                    state_d = SEQ_PARK;
                end
            end
            SEQ_PARK: begin
                if (ss_go && !halt) begin
                    state_d = SEQ_RUN;
                end
            end
            default: state_d = SEQ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_RUN;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end
`else
    assign w_parked   = 1'b0;
    assign w_park_now = 1'b0;
`endif

    assign w_frozen = halt || w_parked;

    always_comb begin
        w_cnt_hold = 1'b1;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        if (!w_frozen && !w_park_now) begin
            w_cnt_hold = 1'b0;
            if (w_in_fetch) begin
                w_cnt_inc = 1'b1;
            end else if (w_end_instr) begin
                w_cnt_clr = 1'b1;
            end else begin
                w_cnt_inc = 1'b1;
            end
        end
    end

    seq_step_counter #(
        .W (STEP_BITS)
    ) u_step_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (w_cnt_hold),
        .clr_i   (w_cnt_clr),
        .inc_i   (w_cnt_inc),
        .count_o (w_step)
    );

    assign step  = w_step;
    assign uaddr = {ir_value[15 -: OPCODE_BITS], w_step};

    generate
        if (OPCODE_BITS < 16) begin : g_ir_low_unused
            logic w_unused_ir_low;
            assign w_unused_ir_low = ^ir_value[15-OPCODE_BITS:0];
        end
    endgenerate

    // Strobes are suppressed while frozen so nothing loads during a stall
    always_comb begin
        fetch     = w_in_fetch && !w_frozen;
        f_pc_en   = (w_step == c_step_pc) && !w_frozen;
        f_ar_load = (w_step == c_step_pc) && !w_frozen;
        f_mem_en  = (w_step == c_step_ir) && !w_frozen;
        f_ir_load = (w_step == c_step_ir) && !w_frozen;
        f_pc_inc  = (w_step == c_step_ir) && !w_frozen;
    end

endmodule : micro_sequencer
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_micro_sequencer
// Brief   : Directed self-checking bench for micro_sequencer (default build;
//           single-step vectors added when SEQ_SINGLE_STEP_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] ir_value;
    logic        urst;
    logic        halt;
    logic [2:0]  step;
    logic [10:0] uaddr;
    logic        fetch;
    logic        f_pc_en;
    logic        f_ar_load;
    logic        f_mem_en;
    logic        f_ir_load;
    logic        f_pc_inc;
`ifdef SEQ_SINGLE_STEP_EN
    logic        ss_mode;
    logic        ss_go;
    logic        ss_waiting;
`endif

    int n_cmp;
    int n_mis;

    micro_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_value   (ir_value),
        .urst       (urst),
        .halt       (halt),
`ifdef SEQ_SINGLE_STEP_EN
        .ss_mode    (ss_mode),
        .ss_go      (ss_go),
        .ss_waiting (ss_waiting),
`endif
        .step       (step),
        .uaddr      (uaddr),
        .fetch      (fetch),
        .f_pc_en    (f_pc_en),
        .f_ar_load  (f_ar_load),
        .f_mem_en   (f_mem_en),
        .f_ir_load  (f_ir_load),
        .f_pc_inc   (f_pc_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes packed as {fetch, pc_en, ar_load, mem_en, ir_load, pc_inc}
    function automatic logic [5:0] strobes();
        return {fetch, f_pc_en, f_ar_load, f_mem_en, f_ir_load, f_pc_inc};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        rst_n    = 1'b1;
        ir_value = 16'h0000;
        urst     = 1'b0;
        halt     = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        ss_mode  = 1'b0;
        ss_go    = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("pre_reset_step", {29'd0, step}, 32'd2);

        // Asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_step", {29'd0, step}, 32'd0);
        check_eq("async_rst_strobes", {26'd0, strobes()}, {26'd0, 6'b111000});
        tick();
        rst_n = 1'b1;

        // urst at step 3 ends the instruction
        ir_value = 16'h2A00;
        do_reset();
        check_eq("t2_s0", {29'd0, step}, 32'd0);
        tick();
        check_eq("t2_s1", {29'd0, step}, 32'd1);
        check_eq("t2_s1_strobes", {26'd0, strobes()}, {26'd0, 6'b100111});
        tick();
        check_eq("t2_s2", {29'd0, step}, 32'd2);
        check_eq("t2_uaddr", {21'd0, uaddr}, 32'h152);
        check_eq("t2_s2_strobes", {26'd0, strobes()}, 32'd0);
        tick();
        check_eq("t2_s3", {29'd0, step}, 32'd3);
        urst = 1'b1;
        tick();
        urst = 1'b0;
        check_eq("t2_back0", {29'd0, step}, 32'd0);

        // urst held from reset: ignored during fetch
        urst = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check_eq("t3_step", {29'd0, step}, i % 3);
            tick();
        end
        urst = 1'b0;

        // No urst: implicit wrap after step 7
        do_reset();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            check_eq("t4_step", {29'd0, step}, i);
            if (f_pc_inc) pulses++;
            tick();
        end
        check_eq("t4_wrap", {29'd0, step}, 32'd0);
        check_eq("t4_pc_inc_pulses", pulses, 32'd1);

        // Halt at step 1 with urst high
        urst = 1'b1;
        do_reset();
        tick();
        halt = 1'b1;
        #1;
        check_eq("t5_halt_strobes", {26'd0, strobes()}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t5_hold_step", {29'd0, step}, 32'd1);
            check_eq("t5_hold_strobes", {26'd0, strobes()}, 32'd0);
        end
        halt = 1'b0;
        tick();
        check_eq("t5_resume", {29'd0, step}, 32'd2);
        halt = 1'b1;
        tick();
        check_eq("t5_halt_beats_urst", {29'd0, step}, 32'd2);
        halt = 1'b0;
        tick();
        check_eq("t5_urst_after", {29'd0, step}, 32'd0);
        urst = 1'b0;

        // Halt at step 7 blocks the wrap
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        halt = 1'b1;
        tick();
        check_eq("t5_halt_beats_wrap", {29'd0, step}, 32'd7);
        halt = 1'b0;
        tick();
        check_eq("t5_wrap_after", {29'd0, step}, 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
        ss_mode = 1'b1;
        ss_go   = 1'b0;
        do_reset();
        check_eq("t6_rst_wait", {31'd0, ss_waiting}, 32'd0);
        tick();
        check_eq("t6_parked", {31'd0, ss_waiting}, 32'd1);
        check_eq("t6_park_step", {29'd0, step}, 32'd0);
        check_eq("t6_park_strobes", {26'd0, strobes()}, 32'd0);
        tick();
        check_eq("t6_still_parked", {29'd0, step}, {29'd0, 3'd0});
        urst  = 1'b1;
        ss_go = 1'b1;
        tick();
        ss_go = 1'b0;
        check_eq("t6_go_wait", {31'd0, ss_waiting}, 32'd0);
        check_eq("t6_go_strobes", {26'd0, strobes()}, {26'd0, 6'b111000});
        tick();
        check_eq("t6_s1", {29'd0, step}, 32'd1);
        tick();
        check_eq("t6_s2", {29'd0, step}, 32'd2);
        tick();
        check_eq("t6_reparked", {31'd0, ss_waiting}, 32'd1);
        check_eq("t6_repark_step", {29'd0, step}, 32'd0);
        tick();
        check_eq("t6_stays_parked", {31'd0, ss_waiting}, 32'd1);
        urst    = 1'b0;
        ss_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_micro_sequencer
`default_nettype wire
